// File: rtl/i2s_tx_initiator.sv
// Multi-line I2S / left-justified transmitter: clock divider, bit/slot sequencer,
// one-entry sample buffer with underrun reporting and graceful stop at frame boundary.
module i2s_tx_initiator #(
    parameter int unsigned LINES    = 3,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned MODE     = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LINES*SAMPLE_W-1:0]   s_left,
    input  logic [LINES*SAMPLE_W-1:0]   s_right,
    output logic                        sck,
    output logic                        ws,
    output logic [LINES-1:0]            sd,
    output logic                        underrun,
    output logic                        busy
);

    localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned KW = $clog2(2 * SLOT_W);
    localparam int unsigned FW = LINES * SAMPLE_W;

    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);
    localparam logic [KW-1:0] K_LAST = KW'(2 * SLOT_W - 1);
    localparam logic [KW-1:0] K_SLOT = KW'(SLOT_W);
    localparam logic [KW-1:0] K_SAMP = KW'(SAMPLE_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_nx;
    logic [DW-1:0]    dcnt, dcnt_nx;
    logic [KW-1:0]    kn, kn_nx;
    logic             sck_nx, ws_nx, underrun_nx, busy_nx, s_ready_nx;
    logic [LINES-1:0] sd_nx, line_bit;
    logic             buf_full, buf_full_nx;
    logic [FW-1:0]    buf_l, buf_r, buf_l_nx, buf_r_nx;
    logic [FW-1:0]    frm_l, frm_r, frm_l_nx, frm_r_nx;
    logic [FW-1:0]    src_l, src_r;
    logic [KW-1:0]    slot_j;
    logic             right_slot, pad, fall;

    // kn is the index of the bit emitted at the next fall event
    assign fall       = (state != IDLE) && (dcnt == D_LAST);
    assign right_slot = (kn >= K_SLOT);
    assign slot_j     = right_slot ? (kn - K_SLOT) : kn;
    assign pad        = (slot_j >= K_SAMP);
    // At kn == 0 the frame about to start uses the buffer (or silence on underrun)
    assign src_l      = (kn == '0) ? (buf_full ? buf_l : '0) : frm_l;
    assign src_r      = (kn == '0) ? (buf_full ? buf_r : '0) : frm_r;

    for (genvar g = 0; g < LINES; g++) begin : g_line
        logic [SAMPLE_W-1:0] word, shifted;
        assign word        = right_slot ? src_r[g*SAMPLE_W +: SAMPLE_W]
                                        : src_l[g*SAMPLE_W +: SAMPLE_W];
        assign shifted     = word << slot_j;
        assign line_bit[g] = ~pad & shifted[SAMPLE_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            dcnt     <= '0;
            kn       <= '0;
            sck      <= 1'b0;
            ws       <= 1'b0;
            sd       <= '0;
            underrun <= 1'b0;
            busy     <= 1'b0;
            s_ready  <= 1'b0;
            buf_full <= 1'b0;
            buf_l    <= '0;
            buf_r    <= '0;
            frm_l    <= '0;
            frm_r    <= '0;
        end else begin
            state    <= state_nx;
            dcnt     <= dcnt_nx;
            kn       <= kn_nx;
            sck      <= sck_nx;
            ws       <= ws_nx;
            sd       <= sd_nx;
            underrun <= underrun_nx;
            busy     <= busy_nx;
            s_ready  <= s_ready_nx;
            buf_full <= buf_full_nx;
            buf_l    <= buf_l_nx;
            buf_r    <= buf_r_nx;
            frm_l    <= frm_l_nx;
            frm_r    <= frm_r_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        dcnt_nx     = '0;
        kn_nx       = kn;
        sck_nx      = 1'b0;
        ws_nx       = ws;
        sd_nx       = sd;
        underrun_nx = 1'b0;
        buf_full_nx = buf_full;
        buf_l_nx    = buf_l;
        buf_r_nx    = buf_r;
        frm_l_nx    = frm_l;
        frm_r_nx    = frm_r;

        case (state)
            IDLE:    if (enable) state_nx = RUN;
            RUN:     if (!enable) state_nx = DRAIN;
            DRAIN: begin
                if (enable)                 state_nx = RUN;
                else if (fall && kn == '0)  state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (state == IDLE || state_nx == IDLE) begin
            kn_nx = '0;
            ws_nx = 1'b0;
            sd_nx = '0;
        end else begin
            dcnt_nx = fall ? '0 : dcnt + DW'(1);
            sck_nx  = (dcnt_nx >= D_HALF);
            if (fall) begin
                kn_nx = (kn == K_LAST) ? '0 : kn + KW'(1);
                ws_nx = (MODE != 0) ? right_slot : (kn_nx >= K_SLOT);
                sd_nx = line_bit;
                // Frame start: buffer moves into the frame registers
                if (kn == '0) begin
                    underrun_nx = ~buf_full;
                    frm_l_nx    = src_l;
                    frm_r_nx    = src_r;
                    buf_full_nx = 1'b0;
                end
            end
        end

        if (s_valid && s_ready) begin
            buf_l_nx    = s_left;
            buf_r_nx    = s_right;
            buf_full_nx = 1'b1;
        end

        s_ready_nx = ~buf_full_nx;
        busy_nx    = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_i2s_tx_initiator.sv
// Directed bench for i2s_tx_initiator: default (MODE 0), left-justified 16/16,
// and a 4-line CLK_DIV=2 instance sharing clock and reset.
module tb_i2s_tx_initiator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default instance: LINES=3, SAMPLE_W=16, SLOT_W=32, CLK_DIV=4, MODE=0
    logic        en0, v0, rdy0, sck0, ws0, ur0, busy0;
    logic [47:0] l0, r0;
    logic [2:0]  sd0;
    // Left-justified, no padding
    logic        en1, v1, rdy1, sck1, ws1, ur1, busy1;
    logic [15:0] l1, r1;
    logic [0:0]  sd1;
    // Four lines, fastest divider
    logic        en2, v2, rdy2, sck2, ws2, ur2, busy2;
    logic [31:0] l2, r2;
    logic [3:0]  sd2;

    i2s_tx_initiator dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .s_valid(v0), .s_ready(rdy0),
        .s_left(l0), .s_right(r0), .sck(sck0), .ws(ws0), .sd(sd0),
        .underrun(ur0), .busy(busy0));

    i2s_tx_initiator #(.LINES(1), .SAMPLE_W(16), .SLOT_W(16), .CLK_DIV(4), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .s_valid(v1), .s_ready(rdy1),
        .s_left(l1), .s_right(r1), .sck(sck1), .ws(ws1), .sd(sd1),
        .underrun(ur1), .busy(busy1));

    i2s_tx_initiator #(.LINES(4), .SAMPLE_W(8), .SLOT_W(8), .CLK_DIV(2), .MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en2), .s_valid(v2), .s_ready(rdy2),
        .s_left(l2), .s_right(r2), .sck(sck2), .ws(ws2), .sd(sd2),
        .underrun(ur2), .busy(busy2));

    int checks = 0;
    int errors = 0;

    logic [127:0] cap_sd [0:2];
    logic [127:0] cap_ws;
    int           cap_n, cap_r0, cap_r64;
    int           cap_ur [$];

    // Records dut0 sd/ws at each sck rise; the sck pulse that precedes the first fall event is skipped
    task automatic capture0(input int nbits, input int budget);
        int   cyc;
        logic prev;
        bit   lead;
        cyc = 0; prev = sck0; lead = 1'b1; cap_n = 0; cap_r0 = -1; cap_r64 = -1;
        for (int ln = 0; ln < 3; ln++) cap_sd[ln] = '0;
        cap_ws = '0;
        cap_ur.delete();
        while (cap_n < nbits && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ur0 === 1'b1) cap_ur.push_back(cyc);
            if (sck0 === 1'b1 && prev === 1'b0) begin
                if (lead) lead = 1'b0;
                else begin
                    for (int ln = 0; ln < 3; ln++) cap_sd[ln] = {cap_sd[ln][126:0], sd0[ln]};
                    cap_ws = {cap_ws[126:0], ws0};
                    if (cap_n == 0)  cap_r0  = cyc;
                    if (cap_n == 64) cap_r64 = cyc;
                    cap_n++;
                end
            end
            prev = sck0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en0 = 0; v0 = 0; l0 = '0; r0 = '0;
        en1 = 0; v1 = 0; l1 = '0; r1 = '0;
        en2 = 0; v2 = 0; l2 = '0; r2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sck0, ws0, sd0, ur0, busy0, rdy0} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000000", {sck0, ws0, sd0, ur0, busy0, rdy0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", rdy0); end
    endtask

    task automatic test_frame();
        logic [127:0] exp_sd, exp_ws;
        l0 = {3{16'hA5C3}}; r0 = {3{16'h0F0F}}; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        checks++;
        if (rdy0 !== 1'b0) begin errors++; $display("FAIL load_ready got %b want 0", rdy0); end
        en0 = 1'b1;
        capture0(128, 1200);
        en0 = 1'b0;
        checks++;
        if (cap_n != 128) begin errors++; $display("FAIL frame_timeout got %0d bits want 128", cap_n); end
        exp_sd = {16'hA5C3, 16'h0000, 16'h0F0F, 16'h0000, 64'h0};
        exp_ws = {31'h0, 32'hFFFF_FFFF, 1'b0, 31'h0, 32'hFFFF_FFFF, 1'b0};
        for (int ln = 0; ln < 3; ln++) begin
            checks++;
            if (cap_sd[ln] !== exp_sd) begin
                errors++;
                $display("FAIL frame_sd line %0d got %h want %h", ln, cap_sd[ln], exp_sd);
            end
        end
        checks++;
        if (cap_ws !== exp_ws) begin errors++; $display("FAIL frame_ws got %h want %h", cap_ws, exp_ws); end
        checks++;
        if (cap_r64 - cap_r0 != 256) begin
            errors++; $display("FAIL frame_period got %0d want 256", cap_r64 - cap_r0);
        end
        checks++;
        if (cap_ur.size() != 1 || cap_ur[0] != cap_r64 - 2) begin
            errors++;
            $display("FAIL underrun_pulse got %0d pulses first at %0d want 1 at %0d",
                     cap_ur.size(), (cap_ur.size() > 0) ? cap_ur[0] : -1, cap_r64 - 2);
        end
        for (int i = 0; i < 600 && busy0 !== 1'b0; i++) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL frame_stop_busy got %b want 0", busy0); end
    endtask

    task automatic test_drain();
        int   b, cyc, gap;
        logic prev;
        bit   lead;
        en0 = 1'b1; b = -1; lead = 1'b1; prev = 1'b0; cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (sck0 === 1'b1 && prev === 1'b0) begin
                if (lead) lead = 1'b0;
                else begin b++; if (b == 10) en0 = 1'b0; end
            end
            prev = sck0;
        end while (busy0 === 1'b1 && cyc < 1000);
        checks++;
        if (busy0 !== 1'b0 || b != 63) begin
            errors++; $display("FAIL drain_last_bit got %0d busy %b want 63 busy 0", b, busy0);
        end
        gap = 0;
        repeat (16) begin
            @(negedge clk);
            if (sck0 !== 1'b0 || busy0 !== 1'b0) gap++;
        end
        checks++;
        if (gap != 0) begin errors++; $display("FAIL drain_quiet got %0d active cycles want 0", gap); end

        en0 = 1'b1; b = -1; lead = 1'b1; prev = 1'b0; cyc = 0; gap = 0;
        while (b < 70 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (busy0 !== 1'b1) gap++;
            if (sck0 === 1'b1 && prev === 1'b0) begin
                if (lead) lead = 1'b0;
                else begin
                    b++;
                    if (b == 10) en0 = 1'b0;
                    if (b == 40) en0 = 1'b1;
                end
            end
            prev = sck0;
        end
        en0 = 1'b0;
        checks++;
        if (b < 70) begin errors++; $display("FAIL reassert_progress got %0d want 70", b); end
        checks++;
        if (gap != 0) begin errors++; $display("FAIL reassert_busy_gap got %0d want 0", gap); end
        for (int i = 0; i < 600 && busy0 !== 1'b0; i++) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL reassert_stop got %b want 0", busy0); end
    endtask

    task automatic test_reset_midframe();
        int   b, cyc;
        logic prev;
        bit   lead;
        l0 = {3{16'hFFFF}}; r0 = {3{16'hFFFF}}; v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0; en0 = 1'b1; b = -1; lead = 1'b1; prev = 1'b0; cyc = 0;
        while (b < 20 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            v0 = 1'b0;
            if (sck0 === 1'b1 && prev === 1'b0) begin
                if (lead) lead = 1'b0;
                else begin
                    b++;
                    if (b == 5) begin l0 = {3{16'hBEEF}}; r0 = {3{16'hCAFE}}; v0 = 1'b1; end
                end
            end
            prev = sck0;
        end
        checks++;
        if (b != 20 || rdy0 !== 1'b0) begin
            errors++; $display("FAIL midframe_setup got bit %0d ready %b want 20 0", b, rdy0);
        end
        rst_n = 1'b0; en0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({sck0, ws0, sd0, ur0, busy0, rdy0} !== 8'h00) begin
            errors++;
            $display("FAIL midframe_reset got %b want 00000000", {sck0, ws0, sd0, ur0, busy0, rdy0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL midframe_release_ready got %b want 1", rdy0); end
        en0 = 1'b1;
        capture0(64, 600);
        en0 = 1'b0;
        checks++;
        if (cap_n != 64 || (cap_sd[0] | cap_sd[1] | cap_sd[2]) !== 128'h0) begin
            errors++;
            $display("FAIL midframe_stale got %0d bits or %h want 64 bits of 0",
                     cap_n, cap_sd[0] | cap_sd[1] | cap_sd[2]);
        end
        checks++;
        if (cap_ur.size() != 1) begin
            errors++; $display("FAIL midframe_underrun got %0d want 1", cap_ur.size());
        end
        for (int i = 0; i < 600 && busy0 !== 1'b0; i++) @(negedge clk);
    endtask

    task automatic test_mode1();
        logic [31:0] got_sd, got_ws;
        int          n, cyc;
        logic        prev;
        bit          lead;
        l1 = 16'hC35A; r1 = 16'h1234; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0; en1 = 1'b1;
        n = 0; cyc = 0; prev = 1'b0; lead = 1'b1; got_sd = '0; got_ws = '0;
        while (n < 32 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (sck1 === 1'b1 && prev === 1'b0) begin
                if (lead) lead = 1'b0;
                else begin got_sd = {got_sd[30:0], sd1[0]}; got_ws = {got_ws[30:0], ws1}; n++; end
            end
            prev = sck1;
        end
        en1 = 1'b0;
        checks++;
        if (n != 32 || got_sd !== 32'hC35A_1234) begin
            errors++; $display("FAIL lj_sd got %h (%0d bits) want c35a1234", got_sd, n);
        end
        checks++;
        if (got_ws !== 32'h0000_FFFF) begin errors++; $display("FAIL lj_ws got %h want 0000ffff", got_ws); end
        for (int i = 0; i < 300 && busy1 !== 1'b0; i++) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL lj_stop got %b want 0", busy1); end
    endtask

    task automatic test_lanes();
        logic [15:0] got [0:3];
        logic [15:0] exp_line;
        int          n, cyc, tog_err;
        logic        prev;
        bit          lead;
        l2 = {8'h18, 8'h24, 8'h42, 8'h81};
        r2 = {8'h55, 8'hAA, 8'h0F, 8'hF0};
        v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0; en2 = 1'b1;
        n = 0; cyc = 0; prev = 1'b0; lead = 1'b1; tog_err = 0;
        for (int ln = 0; ln < 4; ln++) got[ln] = '0;
        while (n < 16 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!lead && sck2 === prev) tog_err++;
            if (sck2 === 1'b1 && prev === 1'b0) begin
                if (lead) lead = 1'b0;
                else begin
                    for (int ln = 0; ln < 4; ln++) got[ln] = {got[ln][14:0], sd2[ln]};
                    n++;
                end
            end
            prev = sck2;
        end
        en2 = 1'b0;
        for (int ln = 0; ln < 4; ln++) begin
            exp_line = {l2[ln*8 +: 8], r2[ln*8 +: 8]};
            checks++;
            if (n != 16 || got[ln] !== exp_line) begin
                errors++; $display("FAIL lane_sd line %0d got %h want %h", ln, got[ln], exp_line);
            end
        end
        checks++;
        if (tog_err != 0) begin errors++; $display("FAIL lane_sck_toggle got %0d stalls want 0", tog_err); end
        for (int i = 0; i < 200 && busy2 !== 1'b0; i++) @(negedge clk);
        checks++;
        if (busy2 !== 1'b0) begin errors++; $display("FAIL lane_stop got %b want 0", busy2); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_drain();
        test_reset_midframe();
        test_mode1();
        test_lanes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
